// File: rtl/multi_bank_bram_loader_pkg.sv
// Shared definitions for the multi-bank BRAM loader: width helper and the
// IDLE/LOAD/DONE state encoding, which the control FSM may decode as status.
package multi_bank_bram_loader_pkg;

  // Ceiling log2, never below 1 so that single-entry fields keep one bit.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return (r == 0) ? 32'd1 : r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multi_bank_bram_loader_bank_addr_counter.sv
// Bank/address cursor for the loader: bank_sel walks 0..BANKS-1 with a
// compare-based wrap (BANKS need not be a power of two); addr advances on
// each bank wrap, modulo DEPTH, wrapping silently.
// Ports: clk, rst (sync, active-high), load/load_addr (restart at bank 0,
// addr load_addr), en (advance by one word), bank_sel, addr.
module multi_bank_bram_loader_bank_addr_counter
  import multi_bank_bram_loader_pkg::*;
#(
  parameter int unsigned BANKS = 4,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned ADDR  = log2(DEPTH),
  parameter int unsigned SEL   = log2(BANKS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [ADDR-1:0] load_addr,
  input  logic            en,
  output logic [SEL-1:0]  bank_sel,
  output logic [ADDR-1:0] addr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel <= '0;
      addr     <= '0;
    end else if (load) begin
      bank_sel <= '0;
      addr     <= load_addr;
    end else if (en) begin
      if (bank_sel == SEL'(BANKS - 1)) begin
        bank_sel <= '0;
        addr     <= (addr == ADDR'(DEPTH - 1)) ? '0 : addr + 1'b1;
      end else begin
        bank_sel <= bank_sel + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_bank_bram_loader.sv
// Stream-to-bank write stage feeding port A of a multi-bank BRAM. Word k of a
// load goes to bank k % BANKS at address (base_addr + k / BANKS) mod DEPTH.
// Ports: clk, rst (sync, active-high); start/base_addr/count (load command,
// sampled only in IDLE); s_axis_tdata/tvalid/tready/tlast (+ s_axis_tkeep when
// BRAM_LOADER_TKEEP_EN is defined); ena/wea/addra/dina (registered port-A
// strobes, one slice per bank); busy, done (one-cycle pulse), error (sticky
// framing error, cleared by the next accepted start).
// Option: define BRAM_LOADER_TKEEP_EN to drive each wea slice from tkeep
// instead of all-ones.
module multi_bank_bram_loader
  import multi_bank_bram_loader_pkg::*;
#(
  parameter int unsigned BANKS = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned ADDR  = log2(DEPTH),
  parameter int unsigned WE    = WIDTH / 8,
  parameter int unsigned CNT   = log2(BANKS * DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR-1:0]        base_addr,
  input  logic [CNT-1:0]         count,
  input  logic [WIDTH-1:0]       s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
`ifdef BRAM_LOADER_TKEEP_EN
  input  logic [WE-1:0]          s_axis_tkeep,
`endif
  output logic [BANKS-1:0]       ena,
  output logic [BANKS*WE-1:0]    wea,
  output logic [BANKS*ADDR-1:0]  addra,
  output logic [BANKS*WIDTH-1:0] dina,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned SEL = log2(BANKS);

  state_e          state;
  state_e          state_nxt;
  logic [CNT-1:0]  count_q;
  logic [CNT-1:0]  words;
  logic [SEL-1:0]  bank_sel;
  logic [ADDR-1:0] cur_addr;
  logic [WE-1:0]   keep_c;
  logic            start_c;
  logic            accept_c;
  logic            last_beat_c;
  logic            finish_c;
  logic            frame_err_c;

`ifdef BRAM_LOADER_TKEEP_EN
  assign keep_c = s_axis_tkeep;
`else
  assign keep_c = '1;
`endif

  assign start_c     = start && (state == ST_IDLE);
  assign accept_c    = s_axis_tvalid && s_axis_tready;
  assign last_beat_c = (words == count_q - 1'b1);
  assign finish_c    = accept_c && (last_beat_c || s_axis_tlast);
  // Error when tlast and the counted final beat disagree (early or missing tlast).
  assign frame_err_c = accept_c && (last_beat_c != s_axis_tlast);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (count != '0) ? ST_LOAD : ST_DONE;
      ST_LOAD: if (finish_c) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      s_axis_tready <= (state_nxt == ST_LOAD);
      busy          <= (state_nxt != ST_IDLE);
      done          <= (state_nxt == ST_DONE);
    end
  end

  // Command latch, beat counter and sticky framing error.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      words   <= '0;
      error   <= 1'b0;
    end else if (start_c) begin
      count_q <= count;
      words   <= '0;
      error   <= 1'b0;
    end else if (accept_c) begin
      words <= words + 1'b1;
      if (frame_err_c) error <= 1'b1;
    end
  end

  multi_bank_bram_loader_bank_addr_counter #(
    .BANKS (BANKS),
    .DEPTH (DEPTH),
    .ADDR  (ADDR),
    .SEL   (SEL)
  ) u_bank_addr_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (start_c),
    .load_addr (base_addr),
    .en        (accept_c),
    .bank_sel  (bank_sel),
    .addr      (cur_addr)
  );

  // Port-A strobes: only the selected bank's slices are driven, for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ena   <= '0;
      wea   <= '0;
      addra <= '0;
      dina  <= '0;
    end else begin
      ena   <= '0;
      wea   <= '0;
      addra <= '0;
      dina  <= '0;
      if (accept_c) begin
        for (int b = 0; b < int'(BANKS); b++) begin
          if (SEL'(b) == bank_sel) begin
            ena[b]                   <= 1'b1;
            wea[b*WE +: WE]          <= keep_c;
            addra[b*ADDR +: ADDR]    <= cur_addr;
            dina[b*WIDTH +: WIDTH]   <= s_axis_tdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_bank_bram_loader.sv
// Randomized bench for multi_bank_bram_loader against a transaction-level model:
// word k of a load is expected at bank k%BANKS, addr (base + k/BANKS)%DEPTH.
module tb_multi_bank_bram_loader;

  localparam int unsigned BANKS = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned ADDR  = 8;
  localparam int unsigned WE    = 2;
  localparam int unsigned CNT   = 11;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [ADDR-1:0]        base_addr;
  logic [CNT-1:0]         count;
  logic [WIDTH-1:0]       s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic                   s_axis_tlast;
`ifdef BRAM_LOADER_TKEEP_EN
  logic [WE-1:0]          s_axis_tkeep;
`endif
  logic [BANKS-1:0]       ena;
  logic [BANKS*WE-1:0]    wea;
  logic [BANKS*ADDR-1:0]  addra;
  logic [BANKS*WIDTH-1:0] dina;
  logic                   busy;
  logic                   done;
  logic                   error;

  multi_bank_bram_loader #(
    .BANKS (BANKS), .WIDTH (WIDTH), .DEPTH (DEPTH),
    .ADDR  (ADDR),  .WE    (WE),    .CNT   (CNT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .count         (count),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
`ifdef BRAM_LOADER_TKEEP_EN
    .s_axis_tkeep  (s_axis_tkeep),
`endif
    .ena           (ena),
    .wea           (wea),
    .addra         (addra),
    .dina          (dina),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = idle, 1 = loading, 2 = completion cycle.
  int m_phase = 0;
  int m_base  = 0;
  int m_cnt   = 0;
  int m_k     = 0;
  bit m_err   = 1'b0;
  int dut_strobes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check every output.
  task automatic step(input logic st, input logic [ADDR-1:0] ba, input logic [CNT-1:0] cn,
                      input logic tv, input logic [WIDTH-1:0] td, input logic tl,
                      input logic [WE-1:0] tk);
    logic [BANKS-1:0]       e_ena;
    logic [BANKS*WE-1:0]    e_wea;
    logic [BANKS*ADDR-1:0]  e_addra;
    logic [BANKS*WIDTH-1:0] e_dina;
    logic [WE-1:0]          e_keep;
    int nph;
    int bank;
    start         = st;
    base_addr     = ba;
    count         = cn;
    s_axis_tvalid = tv;
    s_axis_tdata  = td;
    s_axis_tlast  = tl;
`ifdef BRAM_LOADER_TKEEP_EN
    s_axis_tkeep  = tk;
    e_keep        = tk;
`else
    e_keep        = '1;
    if (tk == '0) e_keep = '1;
`endif
    e_ena = '0; e_wea = '0; e_addra = '0; e_dina = '0;
    nph = m_phase;
    if (m_phase == 2) begin
      nph = 0;
    end else if (m_phase == 0) begin
      if (st) begin
        m_base = int'(ba); m_cnt = int'(cn); m_k = 0; m_err = 1'b0;
        nph = (m_cnt == 0) ? 2 : 1;
      end
    end else if (tv) begin
      bank = m_k % BANKS;
      e_ena[bank]                  = 1'b1;
      e_wea[bank*WE +: WE]         = e_keep;
      e_addra[bank*ADDR +: ADDR]   = ADDR'((m_base + m_k / BANKS) % DEPTH);
      e_dina[bank*WIDTH +: WIDTH]  = td;
      if (m_k == m_cnt - 1) begin
        nph = 2;
        if (!tl) m_err = 1'b1;
      end else if (tl) begin
        nph = 2;
        m_err = 1'b1;
      end
      m_k++;
    end
    m_phase = nph;
    @(posedge clk); #1;
    chk("ena",    64'(ena),   64'(e_ena));
    chk("wea",    64'(wea),   64'(e_wea));
    chk("addra",  64'(addra), 64'(e_addra));
    chk("dina",   64'(dina),  64'(e_dina));
    chk("tready", 64'(s_axis_tready), 64'(m_phase == 1));
    chk("busy",   64'(busy),  64'(m_phase != 0));
    chk("done",   64'(done),  64'(m_phase == 2));
    chk("error",  64'(error), 64'(m_err));
    dut_strobes += $countones(ena);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; m_phase = 0; m_err = 1'b0;
    chk("rst_ena",   64'(ena),   64'd0);
    chk("rst_wea",   64'(wea),   64'd0);
    chk("rst_addra", 64'(addra), 64'd0);
    chk("rst_dina",  64'(dina),  64'd0);
    chk("rst_tready",64'(s_axis_tready), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_error", 64'(error), 64'd0);
  endtask

  // vmode: 0 continuous valid, 1 toggling valid, 2 random valid.
  // last_at: beat index carrying tlast (-1 = never). mid_start: loop cycle of a stray start.
  task automatic run_load(input int base, input int cnt, input int last_at, input int vmode,
                          input int mid_start, input int exp_writes);
    int   guard;
    logic tv;
    logic tl;
    dut_strobes = 0;
    step(1'b1, ADDR'(base), CNT'(cnt), 1'b0, '0, 1'b0, '1);
    guard = 0;
    while (m_phase != 0 && guard < 200) begin
      case (vmode)
        0:       tv = 1'b1;
        1:       tv = 1'(guard % 2);
        default: tv = 1'($urandom_range(0, 1));
      endcase
      tl = tv && (m_k == last_at);
      step(guard == mid_start, ADDR'($urandom), CNT'($urandom_range(0, 20)), tv,
           WIDTH'($urandom), tl, WE'($urandom));
      guard++;
    end
    chk("load_bound", 64'(guard < 200), 64'd1);
    // Stream keeps offering beats after completion; none may be accepted.
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, WIDTH'($urandom), 1'b1, '1);
    chk("nwrites", 64'(dut_strobes), 64'((exp_writes >= 0) ? exp_writes : m_k));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
`ifdef BRAM_LOADER_TKEEP_EN
    s_axis_tkeep = '1;
`endif
    do_reset();
    do_reset();

    run_load(10, 8, 7, 0, -1, 8);      // normal load
    run_load(40, 5, 4, 1, -1, 5);      // throttled stream
    run_load(255, 8, 7, 0, -1, 8);     // address wrap
    run_load(7, 6, 2, 0, -1, 3);       // early tlast
    run_load(100, 5, -1, 0, -1, 5);    // missing tlast
    run_load(33, 0, -1, 0, -1, 0);     // zero count
    run_load(30, 8, 7, 0, 3, 8);       // stray start during load

    // Reset in the middle of a load.
    dut_strobes = 0;
    step(1'b1, 8'd20, 11'd12, 1'b0, '0, 1'b0, '1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, WIDTH'($urandom), 1'b0, '1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, WIDTH'($urandom), 1'b0, '1);
    chk("rst_nwrites", 64'(dut_strobes), 64'd3);

`ifdef BRAM_LOADER_TKEEP_EN
    step(1'b1, 8'd3, 11'd2, 1'b0, '0, 1'b0, '1);
    step(1'b0, '0, '0, 1'b1, 16'h1234, 1'b0, 2'b01);
    chk("keep01_wea", 64'(wea[1:0]), 64'd1);
    step(1'b0, '0, '0, 1'b1, 16'h5678, 1'b1, 2'b00);
    chk("keep0_ena", 64'(ena[1]), 64'd1);
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, '1);
`endif

    for (int n = 0; n < 15; n++) begin
      int cnt;
      int la;
      int r;
      cnt = $urandom_range(0, 13);
      r   = $urandom_range(0, 3);
      if (cnt == 0)   la = -1;
      else if (r == 1) la = -1;
      else if (r == 2) la = $urandom_range(0, cnt - 1);
      else             la = cnt - 1;
      run_load($urandom_range(0, 255), cnt, la, 2, $urandom_range(0, 6), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
